// File: rtl/cond_logic.sv
// ARM-style condition gating and flag registers, with a multi-cycle stall for MUL.
// Write gating and Stall are combinational and flags update on the next edge; a passing MUL stalls for MUL_CYCLES-1 cycles.
module cond_logic #(
  parameter int MUL_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  input  logic       IsMul,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       Stall,
  output logic [3:0] Flags
);

  typedef enum logic {IDLE, MUL_WAIT} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(MUL_CYCLES - 2);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [1:0] nz, cv;
  logic       n, z, c, v;
  logic       condex;
  logic       gate;
  logic [1:0] flag_we;

  assign {n, z} = nz;
  assign {c, v} = cv;
  assign Flags  = {nz, cv};

  // Uses only the registered flags, so the result cannot change while a MUL stalls.
  always_comb begin
    condex = 1'b0;
    case (Cond)
      4'b0000: condex = z;
      4'b0001: condex = ~z;
      4'b0010: condex = c;
      4'b0011: condex = ~c;
      4'b0100: condex = n;
      4'b0101: condex = ~n;
      4'b0110: condex = v;
      4'b0111: condex = ~v;
      4'b1000: condex = c & ~z;
      4'b1001: condex = ~c | z;
      4'b1010: condex = (n == v);
      4'b1011: condex = (n != v);
      4'b1100: condex = ~z & (n == v);
      4'b1101: condex = z | (n != v);
      4'b1110: condex = 1'b1;
      default: condex = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    gate      = 1'b0;
    Stall     = 1'b0;
    case (state)
      IDLE: begin
        if (IsMul && condex) begin
          Stall     = 1'b1;
          gate      = 1'b1;
          cnt_nxt   = CNT_LOAD;
          state_nxt = MUL_WAIT;
        end
      end
      MUL_WAIT: begin
        // IsMul is ignored here: the same instruction is still being held upstream.
        if (cnt != 4'd0) begin
          Stall   = 1'b1;
          gate    = 1'b1;
          cnt_nxt = cnt - 4'd1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign PCSrc    = PCS  & condex & ~gate;
  assign RegWrite = RegW & condex & ~NoWrite & ~gate;
  assign MemWrite = MemW & condex & ~gate;
  assign flag_we  = FlagW & {2{condex & ~gate}};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      nz    <= 2'b00;
      cv    <= 2'b00;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (flag_we[1]) nz <= ALUFlags[3:2];
      if (flag_we[0]) cv <= ALUFlags[1:0];
    end
  end

endmodule

// File: tb/tb_cond_logic.sv
// Scoreboarded bench for cond_logic: an instruction-level model predicts each cycle's outputs.
module tb_cond_logic;
  localparam int MUL_CYCLES = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond, ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW, NoWrite, IsMul;
  logic       PCSrc, RegWrite, MemWrite, Stall;
  logic [3:0] Flags;

  cond_logic #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite), .IsMul(IsMul),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .Stall(Stall), .Flags(Flags)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic [3:0] cond;
    logic [3:0] aluf;
    logic [1:0] flagw;
    logic       pcs, regw, memw, nowrite, ismul;
  } stim_t;

  logic [7:0] scb[$];
  int vectors     = 0;
  int miscompares = 0;

  logic [3:0] mflags = 4'b0000;
  int         mleft  = 0;
  stim_t      held;

  // ARM encodes conditions in pairs: odd codes are the negation of the even code below them.
  function automatic logic cond_holds(input logic [3:0] cc, input logic [3:0] f);
    logic fn, fz, fc, fv, b;
    {fn, fz, fc, fv} = f;
    case (cc[3:1])
      3'd0: b = fz;
      3'd1: b = fc;
      3'd2: b = fn;
      3'd3: b = fv;
      3'd4: b = fc && !fz;
      3'd5: b = (fn == fv);
      3'd6: b = (fn == fv) && !fz;
      default: b = 1'b1;
    endcase
    return cc[0] ? !b : b;
  endfunction

  function automatic stim_t mk(input logic [3:0] cc, input logic [3:0] af, input logic [1:0] fw,
                               input logic pcs, input logic rw, input logic mw,
                               input logic nw, input logic im, input logic rs);
    stim_t s;
    s.rst = rs; s.cond = cc; s.aluf = af; s.flagw = fw;
    s.pcs = pcs; s.regw = rw; s.memw = mw; s.nowrite = nw; s.ismul = im;
    return s;
  endfunction

  // A passing MUL is seen as one instruction presented for MUL_CYCLES cycles; only its last cycle commits.
  task automatic model_push(input stim_t s);
    logic ok, commit, stl;
    logic [3:0] nf;
    ok     = cond_holds(s.cond, mflags);
    commit = 1'b1;
    stl    = 1'b0;
    if (mleft == 0) begin
      if (s.ismul && ok) begin
        stl = 1'b1; commit = 1'b0; mleft = MUL_CYCLES - 1;
      end
    end else if (mleft > 1) begin
      stl = 1'b1; commit = 1'b0; mleft = mleft - 1;
    end else begin
      mleft = 0;
    end
    scb.push_back({s.pcs && ok && commit,
                   s.regw && ok && !s.nowrite && commit,
                   s.memw && ok && commit,
                   stl, mflags});
    nf = mflags;
    if (commit && ok && s.flagw[1]) nf[3:2] = s.aluf[3:2];
    if (commit && ok && s.flagw[0]) nf[1:0] = s.aluf[1:0];
    mflags = nf;
    if (s.rst) begin
      mflags = 4'b0000;
      mleft  = 0;
    end
  endtask

  task automatic cyc(input stim_t s);
    @(posedge clk);
    #1;
    reset = s.rst; Cond = s.cond; ALUFlags = s.aluf; FlagW = s.flagw;
    PCS = s.pcs; RegW = s.regw; MemW = s.memw; NoWrite = s.nowrite; IsMul = s.ismul;
    held = s;
    model_push(s);
  endtask

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin : monitor
    logic [7:0] exp, act;
    forever begin
      @(negedge clk);
      if (scb.size() > 0) begin
        exp = scb.pop_front();
        act = {PCSrc, RegWrite, MemWrite, Stall, Flags};
        vectors++;
        if (act !== exp) begin
          miscompares++;
          $display("FAIL vec {PCSrc,RegWrite,MemWrite,Stall,Flags}: got %b expected %b at %0t", act, exp, $time);
        end
      end
    end
  end

  localparam logic [3:0] AL = 4'b1110;

  initial begin : stimulus
    stim_t      s;
    logic [3:0] exp_st, exp_rw;
    reset = 1'b1; Cond = 4'b0; ALUFlags = 4'b0; FlagW = 2'b0;
    PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0; IsMul = 1'b0;
    repeat (2) @(posedge clk);

    cyc(mk(4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0));
    settle(); chk("reset_flags", Flags, 4'b0000); chk("reset_stall", {3'b0, Stall}, 4'd0);

    cyc(mk(AL, 4'b0100, 2'b11, 0, 0, 0, 0, 0, 0));
    cyc(mk(4'b0000, 4'b0000, 2'b00, 0, 1, 0, 0, 0, 0));
    settle(); chk("flag_update", Flags, 4'b0100); chk("eq_regwrite", {3'b0, RegWrite}, 4'd1);
    cyc(mk(4'b0001, 4'b0000, 2'b00, 0, 1, 0, 0, 0, 0));
    settle(); chk("ne_regwrite", {3'b0, RegWrite}, 4'd0);

    cyc(mk(AL, 4'b1111, 2'b11, 0, 0, 0, 0, 0, 0));
    cyc(mk(AL, 4'b0000, 2'b10, 0, 0, 0, 0, 0, 0));
    cyc(mk(AL, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0));
    settle(); chk("partial_update", Flags, 4'b0011);

    cyc(mk(AL, 4'b1010, 2'b11, 0, 1, 0, 1, 0, 0));
    settle(); chk("cmp_regwrite", {3'b0, RegWrite}, 4'd0);
    cyc(mk(4'b1111, 4'b0000, 2'b00, 1, 0, 0, 0, 0, 0));
    settle(); chk("nv_pcsrc", {3'b0, PCSrc}, 4'd0); chk("cmp_flags", Flags, 4'b1010);

    // Two back-to-back MULs.
    exp_st = 4'b1110; exp_rw = 4'b0001;
    for (int k = 0; k < 2 * MUL_CYCLES; k++) begin
      cyc(mk(AL, 4'b0000, 2'b00, 0, 1, 0, 0, 1, 0));
      settle();
      chk("mul_stall", {3'b0, Stall}, {3'b0, exp_st[3 - (k % 4)]});
      chk("mul_regwrite", {3'b0, RegWrite}, {3'b0, exp_rw[3 - (k % 4)]});
    end
    cyc(mk(4'b1111, 4'b0000, 2'b00, 0, 1, 0, 0, 1, 0));
    settle(); chk("mul_fail_stall", {3'b0, Stall}, 4'd0);

    cyc(mk(AL, 4'b1001, 2'b11, 0, 0, 0, 0, 0, 0));
    cyc(mk(AL, 4'b0000, 2'b00, 0, 1, 0, 0, 1, 0));
    settle(); chk("abort_c1_stall", {3'b0, Stall}, 4'd1);
    cyc(mk(AL, 4'b0000, 2'b00, 0, 1, 0, 0, 1, 1));
    cyc(mk(AL, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0));
    settle();
    chk("abort_stall", {3'b0, Stall}, 4'd0);
    chk("abort_regwrite", {3'b0, RegWrite}, 4'd0);
    chk("abort_flags", Flags, 4'b0000);

    cyc(mk(AL, 4'b1000, 2'b11, 0, 0, 0, 0, 0, 0));
    cyc(mk(4'b1010, 4'b0000, 2'b00, 0, 0, 1, 0, 0, 0));
    settle(); chk("ge_memwrite", {3'b0, MemWrite}, 4'd0);
    cyc(mk(4'b1011, 4'b0000, 2'b00, 0, 0, 1, 0, 0, 0));
    settle(); chk("lt_memwrite", {3'b0, MemWrite}, 4'd1);
    cyc(mk(AL, 4'b0100, 2'b11, 0, 0, 0, 0, 0, 0));
    cyc(mk(4'b1100, 4'b0000, 2'b00, 0, 0, 1, 0, 0, 0));
    settle(); chk("gt_memwrite", {3'b0, MemWrite}, 4'd0);
    cyc(mk(4'b1101, 4'b0000, 2'b00, 0, 0, 1, 0, 0, 0));
    settle(); chk("le_memwrite", {3'b0, MemWrite}, 4'd1);

    // Random traffic; a stalled instruction is held, but reset may still strike mid-MUL.
    for (int i = 0; i < 3000; i++) begin
      if (mleft > 0) begin
        s = held;
      end else begin
        s = mk(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0), 1'b0);
      end
      s.rst = ($urandom_range(0, 63) == 0);
      cyc(s);
    end

    settle();
    #1;
    vectors++;
    if (scb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", scb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cond_logic.md
COND_LOGIC -- requirements
Module: cond_logic

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 4, range 2..15: total clock cycles a passing MUL instruction occupies.
REQ-002 SHALL have port clk  input  1  rising-edge clock, single clock domain.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port Cond  input  4  instruction condition field Instr[31:28].
REQ-005 SHALL have port ALUFlags  input  4  {N,Z,C,V} from ALU for the current instruction.
REQ-006 SHALL have port FlagW  input  2  decoder flag-write request: bit1 = N,Z; bit0 = C,V.
REQ-007 SHALL have port PCS  input  1  decoder PC-write request (branch or write to R15).
REQ-008 SHALL have port RegW  input  1  decoder register-write request.
REQ-009 SHALL have port MemW  input  1  decoder memory-write request.
REQ-010 SHALL have port NoWrite  input  1  decoder suppress-register-write (CMP).
REQ-011 SHALL have port IsMul  input  1  current instruction is MUL (decoder ALUControl = 3'b100).
REQ-012 SHALL have port PCSrc  output  1  gated PC-write select.
REQ-013 SHALL have port RegWrite  output  1  gated register-file write enable.
REQ-014 SHALL have port MemWrite  output  1  gated data-memory write enable.
REQ-015 SHALL have port Stall  output  1  hold PC and instruction; high while a MUL is in progress.
REQ-016 SHALL have port Flags  output  4  registered {N,Z,C,V} status flags.

Function
REQ-017 SHALL hold flags in two registers: NZ = Flags[3:2], CV = Flags[1:0].
REQ-018 SHALL compute CondEx combinationally from Cond and the registered Flags only (never ALUFlags).
REQ-019 SHALL decode Cond per ARM: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
REQ-020 SHALL decode Cond per ARM: 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1.
REQ-021 SHALL treat Cond 1111 as never-execute: CondEx = 0.
REQ-022 SHALL, when not gated, drive PCSrc = PCS&CondEx, RegWrite = RegW&CondEx&!NoWrite, MemWrite = MemW&CondEx.
REQ-023 SHALL, when not gated, update on the rising edge: NZ <= ALUFlags[3:2] if FlagW[1]&CondEx; CV <= ALUFlags[1:0] if FlagW[0]&CondEx; otherwise hold.
REQ-024 SHALL implement a two-state FSM, IDLE and MUL_WAIT, with a 4-bit down-counter cnt.
REQ-025 SHALL, in IDLE with IsMul&CondEx, assert Stall = 1, gate PCSrc/RegWrite/MemWrite to 0, suppress flag writes, load cnt <= MUL_CYCLES-2, and go to MUL_WAIT.
REQ-026 SHALL, in IDLE with IsMul&!CondEx, behave as a normal failed-condition instruction: Stall 0, all write outputs 0, stay in IDLE.
REQ-027 SHALL, in MUL_WAIT with cnt != 0, assert Stall = 1, gate all write outputs and flag writes, and decrement cnt.
REQ-028 SHALL, in MUL_WAIT with cnt == 0, deassert Stall, apply normal gating (REQ-022/023), and return to IDLE.
REQ-029 SHALL therefore hold a passing MUL for exactly MUL_CYCLES cycles, with RegWrite high only in the last cycle.
REQ-030 SHALL keep CondEx stable across a MUL, since flags are frozen while Stall = 1.
REQ-031 SHALL ignore IsMul while in MUL_WAIT; the instruction is held upstream.
REQ-032 SHALL accept back-to-back MULs: the cycle after a MUL's release re-evaluates IDLE entry for the next instruction.

Reset
REQ-033 SHALL, while reset = 1 at a clock edge, set Flags = 4'b0000, state = IDLE, and cnt = 0.
REQ-034 SHALL drive Stall = 0 in the cycle after reset, including when reset aborts a MUL mid-sequence; no RegWrite is issued for the aborted MUL.
REQ-035 SHALL give all outputs defined (non-X) values one cycle after reset is asserted, for any input values.

Verification
REQ-036 SHALL check flag update: after reset, FlagW=11, Cond=1110, ALUFlags=0100 for one edge -> Flags=0100; then Cond=0000 (EQ), RegW=1 -> RegWrite=1; Cond=0001 -> RegWrite=0.
REQ-037 SHALL check partial update: Flags=1111, FlagW=10, ALUFlags=0000, Cond=1110 -> Flags=0011.
REQ-038 SHALL check CMP: Cond=1110, RegW=1, NoWrite=1, FlagW=11 -> RegWrite=0 and flags updated; Cond=1111, PCS=1 -> PCSrc=0.
REQ-039 SHALL check MUL with MUL_CYCLES=4: IsMul=1, Cond=1110, RegW=1 -> Stall=1,1,1,0 over 4 cycles and RegWrite=0,0,0,1.
REQ-040 SHALL check MUL aborted by reset in its 2nd cycle -> next cycle Stall=0, RegWrite=0 with RegW=0, Flags=0000.
REQ-041 SHALL check signed conditions: Flags N=1,V=0 -> GE CondEx=0, LT=1; Flags Z=1 -> GT=0, LE=1 (observed via MemW=1 -> MemWrite).
